// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter that shares one multi-cycle binary-to-BCD converter between
// two requesters, with a start/done handshake, per-requester ack and watchdog abort.
module bcd_conv_arbiter #(
  parameter int BIN_WIDTH = 13,
  parameter int BCD_WIDTH = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           req,
  input  logic [BIN_WIDTH-1:0] bin0,
  input  logic [BIN_WIDTH-1:0] bin1,
  input  logic                 err_clr,
  output logic [1:0]           ack,
  output logic [BCD_WIDTH-1:0] bcd_out,
  output logic                 busy,
  output logic                 last_grant,
  output logic                 timeout_err,
  output logic                 conv_start,
  output logic [BIN_WIDTH-1:0] conv_bin,
  input  logic                 conv_done,
  input  logic [BCD_WIDTH-1:0] conv_bcd
);

  localparam int TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DELIVER} state_e;

  state_e               state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 last_grant_q, last_grant_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [BIN_WIDTH-1:0] conv_bin_q, conv_bin_d;
  logic [BCD_WIDTH-1:0] bcd_out_q, bcd_out_d;
  logic [1:0]           ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 conv_start_q, conv_start_d;
  logic                 timeout_err_q, timeout_err_d;

  logic winner;
  logic timeout_hit;

  // A lone request wins outright; on a tie the requester not served last wins.
  assign winner      = (req == 2'b11) ? ~last_grant_q : req[1];
  assign timeout_hit = (state_q == WAIT) && !conv_done &&
                       (timer_q == TIMER_W'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      timer_q       <= '0;
      conv_bin_q    <= '0;
      bcd_out_q     <= '0;
      ack_q         <= 2'b00;
      busy_q        <= 1'b0;
      conv_start_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      timer_q       <= timer_d;
      conv_bin_q    <= conv_bin_d;
      bcd_out_q     <= bcd_out_d;
      ack_q         <= ack_d;
      busy_q        <= busy_d;
      conv_start_q  <= conv_start_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // NOTE: every signal written in a combinational block gets a default first,
  // otherwise a missed branch would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req != 2'b00) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (conv_done || timeout_hit) state_d = DELIVER;
      DELIVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    timer_d       = timer_q;
    conv_bin_d    = conv_bin_q;
    bcd_out_d     = bcd_out_q;
    timeout_err_d = err_clr ? 1'b0 : timeout_err_q;
    // Outputs are registered, so they are decoded from the state being entered.
    conv_start_d  = (state_d == LAUNCH);
    busy_d        = (state_d != IDLE);
    ack_d         = 2'b00;
    if (state_d == DELIVER) ack_d = grant_q ? 2'b10 : 2'b01;

    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          grant_d    = winner;
          conv_bin_d = winner ? bin1 : bin0;
        end
      end
      LAUNCH: timer_d = '0;
      WAIT: begin
        if (conv_done) begin
          bcd_out_d = conv_bcd;
        end else if (timeout_hit) begin
          bcd_out_d     = '1;
          timeout_err_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DELIVER: last_grant_d = grant_q;
      default: ;
    endcase
  end

  assign ack         = ack_q;
  assign bcd_out     = bcd_out_q;
  assign busy        = busy_q;
  assign last_grant  = last_grant_q;
  assign timeout_err = timeout_err_q;
  assign conv_start  = conv_start_q;
  assign conv_bin    = conv_bin_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: the bench plays the converter and both
// requesters, and predicts grants, results, latency and error state from a simple model.
module tb_bcd_conv_arbiter;

  localparam int BIN_WIDTH = 13;
  localparam int BCD_WIDTH = 16;
  localparam int TIMEOUT   = 64;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [1:0]           req = 2'b00;
  logic [BIN_WIDTH-1:0] bin0 = '0;
  logic [BIN_WIDTH-1:0] bin1 = '0;
  logic                 err_clr = 1'b0;
  logic                 conv_done = 1'b0;
  logic [BCD_WIDTH-1:0] conv_bcd = '0;
  logic [1:0]           ack;
  logic [BCD_WIDTH-1:0] bcd_out;
  logic                 busy;
  logic                 last_grant;
  logic                 timeout_err;
  logic                 conv_start;
  logic [BIN_WIDTH-1:0] conv_bin;

  bcd_conv_arbiter #(
    .BIN_WIDTH(BIN_WIDTH),
    .BCD_WIDTH(BCD_WIDTH),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .bin0       (bin0),
    .bin1       (bin1),
    .err_clr    (err_clr),
    .ack        (ack),
    .bcd_out    (bcd_out),
    .busy       (busy),
    .last_grant (last_grant),
    .timeout_err(timeout_err),
    .conv_start (conv_start),
    .conv_bin   (conv_bin),
    .conv_done  (conv_done),
    .conv_bcd   (conv_bcd)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int starts  = 0;
  int acks    = 0;
  int model_last = 1;
  bit model_err  = 1'b0;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and tally output pulses seen in that cycle.
  task automatic cyc();
    @(negedge clk);
    if (conv_start) starts++;
    if (ack != 2'b00) acks++;
  endtask

  // Entered at the falling edge of an IDLE cycle with req already driven.
  // dly > 0: converter answers dly cycles after conv_start; dly <= 0: never answers.
  task automatic serve(input int dly, input bit hold, input bit stray, input bit clr_same);
    int w, cyc_n, exp_cyc, s0, a0;
    bit to;
    logic [BIN_WIDTH-1:0] op;
    logic [BCD_WIDTH-1:0] exp_bcd;
    w       = (req == 2'b11) ? 1 - model_last : (req[1] ? 1 : 0);
    op      = (w == 1) ? bin1 : bin0;
    to      = (dly <= 0);
    exp_bcd = to ? 16'hFFFF : to_bcd(int'(op));
    exp_cyc = to ? TIMEOUT + 2 : dly + 2;
    s0 = starts;
    a0 = acks;
    conv_done = stray;
    conv_bcd  = 16'hDEAD;
    cyc();
    cyc_n = 1;
    check("start_pulse", 32'(conv_start), 32'd1);
    check("conv_bin", 32'(conv_bin), 32'(op));
    check("busy_launch", 32'(busy), 32'd1);
    bin0 = BIN_WIDTH'($urandom);
    bin1 = BIN_WIDTH'($urandom);
    while (ack == 2'b00 && cyc_n < TIMEOUT + 10) begin
      conv_done = (!to && cyc_n == dly + 1) || (stray && cyc_n == 1);
      conv_bcd  = (!to && cyc_n == dly + 1) ? to_bcd(int'(conv_bin)) : 16'hDEAD;
      err_clr   = clr_same && (cyc_n == TIMEOUT + 1);
      cyc();
      cyc_n++;
    end
    model_err = model_err || to;
    check("ack_cycle", 32'(cyc_n), 32'(exp_cyc));
    check("ack_vector", 32'(ack), (w == 1) ? 32'd2 : 32'd1);
    check("bcd_out", 32'(bcd_out), 32'(exp_bcd));
    check("timeout_err", 32'(timeout_err), 32'(model_err));
    check("start_count", 32'(starts - s0), 32'd1);
    check("last_grant_pre", 32'(last_grant), 32'(model_last));
    conv_done = 1'b0;
    err_clr   = 1'b0;
    if (!hold) req[w] = 1'b0;
    cyc();
    model_last = w;
    check("ack_clear", 32'(ack), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
    check("last_grant", 32'(last_grant), 32'(w));
    check("bcd_hold", 32'(bcd_out), 32'(exp_bcd));
    check("ack_count", 32'(acks - a0), 32'd1);
  endtask

  initial begin
    int s0, a0;

    // Reset values
    repeat (2) cyc();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_start", 32'(conv_start), 32'd0);
    check("rst_conv_bin", 32'(conv_bin), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);
    check("rst_last_grant", 32'(last_grant), 32'd1);
    reset_n = 1'b1;
    cyc();

    // Single request, result 5 cycles after start
    req = 2'b01; bin0 = 13'd1234;
    serve(5, 1'b0, 1'b0, 1'b0);
    check("t1_result", 32'(bcd_out), 32'h1234);

    // Minimum latency from requester 1
    req = 2'b10; bin1 = 13'd4095;
    serve(1, 1'b0, 1'b0, 1'b0);
    check("t6_result", 32'(bcd_out), 32'h4095);

    // Tie held for four conversions: grants alternate starting with requester 0
    req = 2'b11; bin0 = 13'd7; bin1 = 13'd8000;
    s0 = starts; a0 = acks;
    for (int i = 0; i < 4; i++) serve(int'($urandom_range(1, 6)), 1'b1, 1'b0, 1'b0);
    check("t2_starts", 32'(starts - s0), 32'd4);
    check("t2_acks", 32'(acks - a0), 32'd4);
    req = 2'b00;

    // conv_done during IDLE and coincident with conv_start is ignored
    req = 2'b01; bin0 = 13'd555;
    serve(3, 1'b0, 1'b1, 1'b0);
    // conv_done on the last watchdog cycle wins without error
    req = 2'b10; bin1 = 13'd2024;
    serve(TIMEOUT, 1'b0, 1'b0, 1'b0);

    // Watchdog abort, sticky error across a normal conversion, then cleared
    req = 2'b01; bin0 = 13'd99;
    serve(0, 1'b0, 1'b0, 1'b0);
    req = 2'b10; bin1 = 13'd321;
    serve(2, 1'b0, 1'b0, 1'b0);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    model_err = 1'b0;
    check("err_cleared", 32'(timeout_err), 32'd0);
    // Clear coincident with a new abort: set wins
    req = 2'b10; bin1 = 13'd11;
    serve(0, 1'b0, 1'b0, 1'b1);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    model_err = 1'b0;
    check("err_cleared2", 32'(timeout_err), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      req  = 2'($urandom_range(1, 3));
      bin0 = BIN_WIDTH'($urandom);
      bin1 = BIN_WIDTH'($urandom);
      serve(int'($urandom_range(1, 10)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    req = 2'b00;
    cyc();

    // Reset during WAIT, then a late conv_done
    req = 2'b01; bin0 = 13'd4321;
    repeat (3) cyc();
    check("t5_busy_wait", 32'(busy), 32'd1);
    reset_n = 1'b0;
    req = 2'b00;
    #1;
    check("t5_ack", 32'(ack), 32'd0);
    check("t5_bcd", 32'(bcd_out), 32'd0);
    check("t5_start", 32'(conv_start), 32'd0);
    check("t5_conv_bin", 32'(conv_bin), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_last_grant", 32'(last_grant), 32'd1);
    check("t5_err", 32'(timeout_err), 32'd0);
    cyc();
    reset_n = 1'b1;
    model_last = 1;
    a0 = acks;
    cyc();
    conv_done = 1'b1;
    conv_bcd  = 16'h5555;
    cyc();
    conv_done = 1'b0;
    repeat (3) cyc();
    check("t5_no_ack", 32'(acks - a0), 32'd0);
    check("t5_busy_after", 32'(busy), 32'd0);
    check("t5_bcd_after", 32'(bcd_out), 32'd0);
    check("t5_lg_after", 32'(last_grant), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
